// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0]  ADDR_DATA    = 8'h00;
    localparam logic [7:0]  ADDR_CTRL    = 8'h08;
    localparam logic [7:0]  ADDR_BAUD    = 8'h10;
    localparam logic [7:0]  ADDR_ENCODE  = 8'h14;

    localparam logic [15:0] DEF_BAUD_MIN = 16'd16;
    localparam logic [3:0]  NBITS_BIN    = 4'd8;
    localparam logic [3:0]  NBITS_SYM    = 4'd10;

    // Programmed divisors below the floor are clamped up to it.
    function automatic logic [15:0] eff_period(input logic [15:0] div, input logic [15:0] min_p);
        return (div < min_p) ? min_p : div;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Register-write bus and TX status bundle between the control decoder and the TX engine.
interface uart_tx_engine_if;
    logic        wr_en;
    logic [31:0] wdata;
    logic        data_ptr;
    logic        ctrl_ptr;
    logic        baud_ptr;
    logic        encode_ptr;
    logic        txd;
    logic        tx_busy;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;

    modport master (
        output wr_en, wdata, data_ptr, ctrl_ptr, baud_ptr, encode_ptr,
        input  txd, tx_busy, fifo_full, fifo_empty, overflow
    );

    modport slave (
        input  wr_en, wdata, data_ptr, ctrl_ptr, baud_ptr, encode_ptr,
        output txd, tx_busy, fifo_full, fifo_empty, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty; pushes when full and pops when empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    assign w_push      = i_push & ~r_full;
    assign w_pop       = i_pop & ~r_empty;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;
endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: config registers, TX FIFO and start/data/stop serialiser.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RESET = 16'd434,
    parameter logic [15:0] BAUD_MIN   = DEF_BAUD_MIN
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_engine_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        r_tx_en;
    logic [15:0] r_bauddiv;
    logic        r_mode10;
    logic        r_overflow;

    tx_state_t   r_state;
    logic [9:0]  r_shift;
    logic [15:0] r_period;
    logic [15:0] r_timer;
    logic [3:0]  r_nbits;
    logic [3:0]  r_bitcnt;
    logic        r_txd;
    logic        r_busy;

    logic          w_sel_ok;
    logic          w_wr_data;
    logic          w_wr_ctrl;
    logic          w_wr_baud;
    logic          w_wr_enc;
    logic          w_pop;
    logic [9:0]    w_fifo_rdata;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [15:0]   w_period_new;
    logic          w_unused_wdata;

    // Conflicting pointer selects are treated as no access at all.
    assign w_sel_ok  = bus.wr_en & $onehot({bus.data_ptr, bus.ctrl_ptr, bus.baud_ptr, bus.encode_ptr});
    assign w_wr_data = w_sel_ok & bus.data_ptr;
    assign w_wr_ctrl = w_sel_ok & bus.ctrl_ptr;
    assign w_wr_baud = w_sel_ok & bus.baud_ptr;
    assign w_wr_enc  = w_sel_ok & bus.encode_ptr;

    assign w_unused_wdata = ^bus.wdata[31:16];

    assign w_pop        = (r_state == ST_IDLE) & r_tx_en & (w_fifo_count != '0);
    assign w_period_new = eff_period(r_bauddiv, BAUD_MIN);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (10)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wr_data),
        .i_pop   (w_pop),
        .i_wdata (bus.wdata[9:0]),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_en    <= 1'b0;
            r_bauddiv  <= BAUD_RESET;
            r_mode10   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_tx_en   <= bus.wdata[0];
            if (w_wr_baud) r_bauddiv <= bus.wdata[15:0];
            if (w_wr_enc)  r_mode10  <= bus.wdata[0];
            if (w_wr_ctrl && bus.wdata[1])
                r_overflow <= 1'b0;
            else if (w_wr_data && w_fifo_full)
                r_overflow <= 1'b1;
        end
    end

    // Period and width are latched at frame start so mid-frame config writes wait for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_period <= '0;
            r_timer  <= '0;
            r_nbits  <= '0;
            r_bitcnt <= '0;
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                ST_START: r_txd <= 1'b0;
                ST_DATA:  r_txd <= r_shift[0];
                default:  r_txd <= 1'b1;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift  <= r_mode10 ? w_fifo_rdata : {2'b00, w_fifo_rdata[7:0]};
                        r_nbits  <= r_mode10 ? NBITS_SYM : NBITS_BIN;
                        r_period <= w_period_new;
                        r_timer  <= w_period_new - 16'd1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_timer == '0) begin
                        r_timer  <= r_period - 16'd1;
                        r_bitcnt <= r_nbits - 4'd1;
                        r_state  <= ST_DATA;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (r_timer == '0) begin
                        r_shift <= r_shift >> 1;
                        r_timer <= r_period - 16'd1;
                        if (r_bitcnt == '0)
                            r_state <= ST_STOP;
                        else
                            r_bitcnt <= r_bitcnt - 4'd1;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_timer == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.txd        = r_txd;
    assign bus.tx_busy    = r_busy;
    assign bus.fifo_full  = w_fifo_full;
    assign bus.fifo_empty = w_fifo_empty;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame waveforms, FIFO/overflow, clamping, reset and select conflicts.
module tb_uart_tx_engine;
    logic clk = 1'b0;
    logic rst;

    uart_tx_engine_if bif();

    uart_tx_engine #(
        .FIFO_DEPTH (4),
        .BAUD_RESET (16'd434),
        .BAUD_MIN   (16'd16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] P_DATA = 4'b0001;
    localparam logic [3:0] P_CTRL = 4'b0010;
    localparam logic [3:0] P_BAUD = 4'b0100;
    localparam logic [3:0] P_ENC  = 4'b1000;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] ptr, input logic [31:0] d);
        @(negedge clk);
        bif.wr_en = 1'b1;
        {bif.encode_ptr, bif.baud_ptr, bif.ctrl_ptr, bif.data_ptr} = ptr;
        bif.wdata = d;
        @(negedge clk);
        bif.wr_en = 1'b0;
        {bif.encode_ptr, bif.baud_ptr, bif.ctrl_ptr, bif.data_ptr} = 4'b0000;
        bif.wdata = '0;
    endtask

    // Waits for the start bit, then checks every cycle of the frame against the ideal waveform.
    task automatic rx_frame(input string tag, input int nb, input int per,
                            input logic [9:0] exp, output int gap);
        int          bad;
        logic [9:0]  got;
        logic [11:0] bits;
        gap = 0;
        while (bif.txd !== 1'b0 && gap < 20000) begin
            @(negedge clk);
            gap++;
        end
        if (bif.txd !== 1'b0) begin
            chk({tag, " start timeout"}, 32'd1, 32'd0);
            return;
        end
        bits = '0;
        for (int i = 0; i < nb; i++) bits[i+1] = exp[i];
        bits[nb+1] = 1'b1;
        bad = 0;
        got = '0;
        for (int c = 0; c < (nb + 2) * per; c++) begin
            if (c > 0) @(negedge clk);
            if (bif.txd !== bits[c/per]) bad++;
            if ((c % per) == per/2 && c/per >= 1 && c/per <= nb) got[c/per-1] = bif.txd;
        end
        chk({tag, " wave"}, bad, 0);
        chk({tag, " data"}, {22'd0, got}, {22'd0, exp});
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int g;
        int lows;
        rst = 1'b1;
        bif.wr_en = 1'b0;
        bif.wdata = '0;
        {bif.encode_ptr, bif.baud_ptr, bif.ctrl_ptr, bif.data_ptr} = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst txd",      bif.txd,        1);
        chk("rst busy",     bif.tx_busy,    0);
        chk("rst full",     bif.fifo_full,  0);
        chk("rst empty",    bif.fifo_empty, 1);
        chk("rst overflow", bif.overflow,   0);

        // 1: binary frame, 16 clocks per bit, start latency
        wr(P_BAUD, 32'd16);
        wr(P_ENC,  32'd0);
        wr(P_CTRL, 32'd1);
        wr(P_DATA, 32'hA5);
        @(negedge clk);
        chk("t1 txd N+1",  bif.txd,     1);
        chk("t1 busy N+1", bif.tx_busy, 1);
        @(negedge clk);
        chk("t1 txd N+2",  bif.txd,     0);
        rx_frame("t1", 8, 16, 10'h0A5, g);
        chk("t1 busy end",  bif.tx_busy,    0);
        chk("t1 empty end", bif.fifo_empty, 1);

        // 2: 10-bit symbol mode
        wr(P_ENC,  32'd1);
        wr(P_DATA, 32'h2B7);
        rx_frame("t2", 10, 16, 10'h2B7, g);

        // 3: fill FIFO with TX disabled, overflow, clear+enable, back-to-back drain
        wr(P_ENC,  32'd0);
        wr(P_CTRL, 32'd0);
        wr(P_DATA, 32'h11);
        wr(P_DATA, 32'h22);
        wr(P_DATA, 32'h33);
        chk("t3 full@3", bif.fifo_full, 0);
        wr(P_DATA, 32'h44);
        chk("t3 full@4",     bif.fifo_full, 1);
        chk("t3 overflow@4", bif.overflow,  0);
        wr(P_DATA, 32'h55);
        chk("t3 overflow@5", bif.overflow,  1);
        chk("t3 full@5",     bif.fifo_full, 1);
        wr(P_CTRL, 32'h3);
        chk("t3 overflow clr", bif.overflow, 0);
        rx_frame("t3a", 8, 16, 10'h011, g);
        rx_frame("t3b", 8, 16, 10'h022, g);
        chk("t3b gap", g, 2);
        rx_frame("t3c", 8, 16, 10'h033, g);
        chk("t3c gap", g, 2);
        rx_frame("t3d", 8, 16, 10'h044, g);
        chk("t3d gap", g, 2);
        chk("t3 empty", bif.fifo_empty, 1);
        repeat (3) @(negedge clk);
        chk("t3 idle txd", bif.txd, 1);

        // 4: clamp to 16, then 20 written mid-frame applies to the next frame only
        wr(P_CTRL, 32'd0);
        wr(P_BAUD, 32'd5);
        wr(P_DATA, 32'h01);
        wr(P_DATA, 32'h03);
        wr(P_CTRL, 32'd1);
        fork
            rx_frame("t4a", 8, 16, 10'h001, g);
            begin
                repeat (40) @(negedge clk);
                wr(P_BAUD, 32'd20);
            end
        join
        rx_frame("t4b", 8, 20, 10'h003, g);
        chk("t4b gap", g, 2);

        // 5: reset mid-DATA
        wr(P_BAUD, 32'd16);
        wr(P_CTRL, 32'd0);
        wr(P_DATA, 32'h0F);
        wr(P_DATA, 32'h33);
        wr(P_CTRL, 32'd1);
        g = 0;
        while (bif.txd !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("t5 start seen", bif.txd, 0);
        repeat (40) @(negedge clk);
        chk("t5 busy pre", bif.tx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5 txd",   bif.txd,        1);
        chk("t5 busy",  bif.tx_busy,    0);
        chk("t5 empty", bif.fifo_empty, 1);
        chk("t5 full",  bif.fifo_full,  0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bif.txd !== 1'b1) lows++;
        end
        chk("t5 no residual", lows, 0);

        // 6: conflicting selects write nothing
        wr(P_DATA | P_CTRL, 32'h3);
        chk("t6 empty",    bif.fifo_empty, 1);
        chk("t6 overflow", bif.overflow,   0);
        wr(P_BAUD | P_ENC, 32'h15);
        wr(P_DATA, 32'h55);
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bif.txd !== 1'b1) lows++;
        end
        chk("t6 tx_en kept 0", lows, 0);
        chk("t6 queued", bif.fifo_empty, 0);
        wr(P_CTRL, 32'd1);
        rx_frame("t6", 8, 434, 10'h055, g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
